// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: a level-held request with an
// address, answered by a one-cycle acknowledge pulse carrying the data word.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch unit side: issues requests, receives acknowledges.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: serves requests.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, fetches one word at a time from a
// variable-latency instruction memory and holds it for decode until the
// datapath retires it. On retirement the next fetch address is taken from the
// jump target, the branch target or pc+4, in that priority.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [31:0]  pc,
    output logic [31:0]  pcplus4,
    input  logic         advance,
    input  logic         pcsrc,
    input  logic         jump,
    input  logic [31:0]  pcbranch,
    output logic [31:0]  retired
);

    // IDLE is a one-cycle gap after reset, so an acknowledge belonging to a
    // request that reset abandoned lands here and is dropped.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_next;
    logic        r_imem_req;
    logic        w_imem_req_next;
    logic [31:0] r_instr;
    logic [31:0] w_instr_next;
    logic        r_instr_valid;
    logic        w_instr_valid_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_pcplus4;
    logic [31:0] w_pcplus4_next;
    logic [31:0] r_retired;
    logic [31:0] w_retired_next;

    // Candidate next-fetch addresses, all derived from the held instruction.
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_unused_pcbranch_lsbs;

    // Jumps stay inside the 256 MB region of the instruction after the jump;
    // branch targets are forced word aligned regardless of the low bits given.
    assign w_jump_target          = {r_pcplus4[31:28], r_instr[25:0], 2'b00};
    assign w_branch_target        = {pcbranch[31:2], 2'b00};
    assign w_unused_pcbranch_lsbs = ^pcbranch[1:0];

    // State and all output registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_pc          <= 32'h0;
            r_pcplus4     <= 32'h0;
            r_retired     <= 32'h0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_imem_req    <= w_imem_req_next;
            r_instr       <= w_instr_next;
            r_instr_valid <= w_instr_valid_next;
            r_pc          <= w_pc_next;
            r_pcplus4     <= w_pcplus4_next;
            r_retired     <= w_retired_next;
        end
    end

    // Next-state and next-output decode; everything holds unless changed here.
    always_comb begin
        w_state_next       = r_state;
        w_fetch_pc_next    = r_fetch_pc;
        w_imem_req_next    = r_imem_req;
        w_instr_next       = r_instr;
        w_instr_valid_next = r_instr_valid;
        w_pc_next          = r_pc;
        w_pcplus4_next     = r_pcplus4;
        w_retired_next     = r_retired;

        case (r_state)
            S_IDLE: begin
                // Acknowledges are ignored here; the request starts next cycle.
                w_state_next    = S_FETCH;
                w_imem_req_next = 1'b1;
            end

            S_FETCH: begin
                w_imem_req_next = 1'b1;
                if (imem.imem_ack) begin
                    w_instr_next       = imem.imem_rdata;
                    w_pc_next          = r_fetch_pc;
                    w_pcplus4_next     = r_fetch_pc + 32'd4;
                    w_instr_valid_next = 1'b1;
                    w_imem_req_next    = 1'b0;
                    w_state_next       = S_HOLD;
                end
            end

            S_HOLD: begin
                // Stray acknowledges in HOLD are ignored; only retirement moves on.
                w_imem_req_next = 1'b0;
                if (advance) begin
                    w_retired_next = r_retired + 32'd1;
                    if (jump) begin
                        w_fetch_pc_next = w_jump_target;
                    end else if (pcsrc) begin
                        w_fetch_pc_next = w_branch_target;
                    end else begin
                        w_fetch_pc_next = r_pcplus4;
                    end
                    w_instr_valid_next = 1'b0;
                    w_imem_req_next    = 1'b1;
                    w_state_next       = S_FETCH;
                end
            end

            default: begin
                w_state_next       = S_IDLE;
                w_imem_req_next    = 1'b0;
                w_instr_valid_next = 1'b0;
            end
        endcase
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_fetch_pc;
    assign instr          = r_instr;
    assign instr_valid    = r_instr_valid;
    assign pc             = r_pc;
    assign pcplus4        = r_pcplus4;
    assign retired        = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural memory responder drives the fetch port,
// a table of hand-derived transactions covers the directed cases, a reset
// sequence covers the abandoned request, and random transactions are checked
// against a next-PC model built directly from the fetch rules.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        advance;
    logic        pcsrc;
    logic        jump;
    logic [31:0] pcbranch;
    logic [31:0] retired;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .advance     (advance),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .pcbranch    (pcbranch),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_retired = 32'h0;

    typedef struct {
        int          lat;
        logic [31:0] word;
        int          stall;
        logic        ps;
        logic        jp;
        logic [31:0] pb;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Next fetch address from the architectural rules: jump, then branch, then pc+4.
    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                             input logic ps, input logic jp, input logic [31:0] pb);
        logic [31:0] seq;
        seq = cur_pc + 32'd4;
        if (jp)      return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        else if (ps) return pb & 32'hFFFF_FFFC;
        else         return seq;
    endfunction

    // Scribble on the don't-care inputs while nothing is being retired.
    task automatic noise(input logic allow_adv);
        advance  = allow_adv ? 1'($urandom_range(0, 1)) : 1'b0;
        pcsrc    = 1'($urandom_range(0, 1));
        jump     = 1'($urandom_range(0, 1));
        pcbranch = $urandom;
    endtask

    // One fetch/hold/retire transaction; entered and left at a falling edge.
    task automatic run_txn(input int lat, input logic [31:0] word, input int stall,
                           input logic ps, input logic jp, input logic [31:0] pb,
                           input logic [31:0] exp_pc, input logic [31:0] exp_next);
        int w;
        w = 0;
        while (bus.imem_req !== 1'b1 && w < 20) begin
            noise(1'b1);
            @(negedge clk);
            w++;
        end
        chk("req_seen", 32'(bus.imem_req), 32'd1);
        chk("req_addr", bus.imem_addr, exp_pc);
        chk("valid_low_in_fetch", 32'(instr_valid), 32'd0);
        // Memory latency: request held with a stable address until the ack.
        for (int k = 1; k < lat; k++) begin
            noise(1'b1);
            @(negedge clk);
            chk("req_held", {bus.imem_req, bus.imem_addr[30:0]}, {1'b1, exp_pc[30:0]});
        end
        if (lat > 0) begin
            noise(1'b1);
            @(negedge clk);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        noise(1'b1);
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        chk("instr_valid", 32'(instr_valid), 32'd1);
        chk("instr", instr, word);
        chk("pc", pc, exp_pc);
        chk("pcplus4", pcplus4, exp_pc + 32'd4);
        chk("req_drop", 32'(bus.imem_req), 32'd0);
        // Stall in HOLD: nothing may move.
        for (int k = 0; k < stall; k++) begin
            noise(1'b0);
            @(negedge clk);
            chk("stall_instr", instr, word);
            chk("stall_pc", pc, exp_pc);
            chk("stall_state", {30'h0, instr_valid, bus.imem_req}, 32'd2);
            chk("stall_retired", retired, exp_retired);
        end
        advance  = 1'b1;
        pcsrc    = ps;
        jump     = jp;
        pcbranch = pb;
        @(negedge clk);
        exp_retired = exp_retired + 32'd1;
        noise(1'b1);
        chk("retire_valid", 32'(instr_valid), 32'd0);
        chk("retired", retired, exp_retired);
        chk("next_req", 32'(bus.imem_req), 32'd1);
        chk("next_addr", bus.imem_addr, exp_next);
        $display("txn pc=%h instr=%h lat=%0d stall=%0d ps=%b jp=%b -> next=%h retired=%0d",
                 exp_pc, word, lat, stall, ps, jp, bus.imem_addr, retired);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_pcplus4"}, pcplus4, 32'h0);
        chk({tag, "_retired"}, retired, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mpc;
        logic [31:0] nxt;
        logic [31:0] wd;
        logic        ps;
        logic        jp;
        logic [31:0] pb;

        // Straight line, branch, jump-over-branch, stall, wrap through 0.
        // Row 7: pcplus4=0x1000_0024 keeps nibble 1; instr[25:0]=0x0100004 << 2 = 0x0400010.
        tbl[0]  = '{1, 32'h2001_0001, 0,  1'b0, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004};
        tbl[1]  = '{3, 32'h0000_0020, 0,  1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0008};
        tbl[2]  = '{1, 32'h8C08_0000, 0,  1'b0, 1'b0, 32'h0,         32'h0000_0008, 32'h0000_000C};
        tbl[3]  = '{2, 32'h1000_0001, 0,  1'b1, 1'b0, 32'h12,        32'h0000_000C, 32'h0000_0010};
        tbl[4]  = '{1, 32'h1000_0003, 0,  1'b1, 1'b0, 32'h43,        32'h0000_0010, 32'h0000_0040};
        tbl[5]  = '{2, 32'h0000_0000, 10, 1'b0, 1'b0, 32'h0,         32'h0000_0040, 32'h0000_0044};
        tbl[6]  = '{1, 32'h1000_FFFF, 0,  1'b1, 1'b0, 32'h1000_0022, 32'h0000_0044, 32'h1000_0020};
        tbl[7]  = '{3, 32'h0810_0004, 0,  1'b1, 1'b1, 32'h0000_0800, 32'h1000_0020, 32'h1040_0010};
        tbl[8]  = '{1, 32'h0800_0000, 0,  1'b0, 1'b1, 32'h0,         32'h1040_0010, 32'h1000_0000};
        tbl[9]  = '{2, 32'h1000_0004, 0,  1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1000_0000, 32'hFFFF_FFFC};
        tbl[10] = '{1, 32'h0000_0020, 0,  1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000};
        tbl[11] = '{4, 32'h0000_0020, 0,  1'b0, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004};

        reset          = 1'b1;
        advance        = 1'b0;
        pcsrc          = 1'b0;
        jump           = 1'b0;
        pcbranch       = 32'h0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;

        // Reset for three cycles, then the request rises one cycle after IDLE.
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        chk("idle_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        exp_retired = 32'h0;

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].lat, tbl[i].word, tbl[i].stall, tbl[i].ps, tbl[i].jp,
                    tbl[i].pb, tbl[i].exp_pc, tbl[i].exp_next);
            if (i == 2) chk("retired_after_three", retired, 32'd3);
        end

        // Reset while FETCH is waiting; a late ack just after reset must be dropped.
        chk("pre_reset_req", 32'(bus.imem_req), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset_fetch");
        reset          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        exp_retired    = 32'h0;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        chk("late_ack_instr", instr, 32'h0);
        chk("refetch_req", 32'(bus.imem_req), 32'd1);
        chk("refetch_addr", bus.imem_addr, 32'h0);
        run_txn(2, 32'h0000_0020, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);

        // Random transactions against the next-PC model.
        mpc = 32'h4;
        for (int i = 0; i < 40; i++) begin
            wd = $urandom;
            ps = ($urandom_range(0, 2) == 0);
            jp = ($urandom_range(0, 4) == 0);
            pb = $urandom;
            nxt = ref_next(mpc, wd, ps, jp, pb);
            run_txn($urandom_range(1, 5), wd, $urandom_range(0, 3), ps, jp, pb, mpc, nxt);
            mpc = nxt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
